// File: rtl/regfile_pkg.sv
// Shared defaults and types for the general register bank.
package regfile_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 8;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] word_t;

    localparam word_t PC_RESET_DEF = 16'h0002;

endpackage

// File: rtl/regfile_pc_if.sv
// Register bank access bus between the control FSM (master) and the bank (slave).
interface regfile_pc_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;
    logic [ADDR_W-1:0] RdAddrA;
    logic [DATA_W-1:0] RdDataA;
    logic [ADDR_W-1:0] RdAddrB;
    logic [DATA_W-1:0] RdDataB;
    logic              IncrPC;
    logic [DATA_W-1:0] PC;
    logic              PCWrap;

    modport master (
        output WrEn, WrAddr, WrData, RdAddrA, RdAddrB, IncrPC,
        input  RdDataA, RdDataB, PC, PCWrap
    );

    modport slave (
        input  WrEn, WrAddr, WrData, RdAddrA, RdAddrB, IncrPC,
        output RdDataA, RdDataB, PC, PCWrap
    );
endinterface

// File: rtl/regfile_pc_reg_cell.sv
// Single enabled register with a configurable reset value.
module reg_cell #(
    parameter int           W         = 16,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         Clock_i,
    input  logic         Reset_i,
    input  logic         En_i,
    input  logic [W-1:0] D_i,
    output logic [W-1:0] Q_o
);
    // Power-up value matches the reset value so behaviour before the first reset is defined.
    logic [W-1:0] q_q = RESET_VAL;

    // Reset has priority over the load enable.
    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            q_q <= RESET_VAL;
        end else if (En_i) begin
            q_q <= D_i;
        end
    end

    assign Q_o = q_q;
endmodule

// File: rtl/regfile_pc.sv
// General register bank: two async read ports, one write port, one register doubling as PC.
module regfile_pc
    import regfile_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                NUM_REGS = NUM_REGS_DEF,
    parameter int                ADDR_W   = $clog2(NUM_REGS),
    parameter int                PC_INDEX = NUM_REGS - 1,
    parameter logic [DATA_W-1:0] PC_RESET = PC_RESET_DEF,
    parameter int                BYPASS   = 0
) (
    input  logic         Clock_i,
    input  logic         Reset_i,
    regfile_pc_if.slave  bus
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;
    logic              pc_wr;
    logic              pc_wrap_d;
    logic              pc_wrap_q = 1'b0;
    logic [DATA_W-1:0] rd_a_d;
    logic [DATA_W-1:0] rd_b_d;

    assign pc_q  = regs_q[PC_INDEX];
    // An explicit write to the PC slot beats the increment.
    assign pc_wr = bus.WrEn && (bus.WrAddr == ADDR_W'(PC_INDEX));
    assign pc_d  = pc_wr ? bus.WrData : pc_q + DATA_W'(1);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic              cell_en;
        logic [DATA_W-1:0] cell_d;

        if (i == PC_INDEX) begin : g_pc
            assign cell_en = pc_wr || bus.IncrPC;
            assign cell_d  = pc_d;
            reg_cell #(.W(DATA_W), .RESET_VAL(PC_RESET)) u_cell (
                .Clock_i (Clock_i),
                .Reset_i (Reset_i),
                .En_i    (cell_en),
                .D_i     (cell_d),
                .Q_o     (regs_q[i])
            );
        end else begin : g_gp
            assign cell_en = bus.WrEn && (bus.WrAddr == ADDR_W'(i));
            assign cell_d  = bus.WrData;
            reg_cell #(.W(DATA_W), .RESET_VAL('0)) u_cell (
                .Clock_i (Clock_i),
                .Reset_i (Reset_i),
                .En_i    (cell_en),
                .D_i     (cell_d),
                .Q_o     (regs_q[i])
            );
        end
    end

    // Wrap flag only when a real increment carries the PC out of all-ones.
    assign pc_wrap_d = bus.IncrPC && !pc_wr && (pc_q == '1);

    // Registered one-cycle wrap indication.
    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            pc_wrap_q <= 1'b0;
        end else begin
            pc_wrap_q <= pc_wrap_d;
        end
    end

    // Async read ports; optional write-through forwarding, never of the increment result.
    always_comb begin
        rd_a_d = regs_q[bus.RdAddrA];
        rd_b_d = regs_q[bus.RdAddrB];
        if ((BYPASS != 0) && bus.WrEn && !Reset_i) begin
            if (bus.RdAddrA == bus.WrAddr) rd_a_d = bus.WrData;
            if (bus.RdAddrB == bus.WrAddr) rd_b_d = bus.WrData;
        end
    end

    assign bus.RdDataA = rd_a_d;
    assign bus.RdDataB = rd_b_d;
    assign bus.PC      = pc_q;
    assign bus.PCWrap  = pc_wrap_q;
endmodule

// File: tb/tb_regfile_pc.sv
// Directed bench for regfile_pc: one instance without and one with read bypass.
module tb_regfile_pc;
    import regfile_pkg::*;

    typedef struct {
        string tag;
        word_t exp;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_err = 0;

    regfile_pc_if #(.DATA_W(16), .ADDR_W(3)) bus0 ();
    regfile_pc_if #(.DATA_W(16), .ADDR_W(3)) bus1 ();

    regfile_pc #(.BYPASS(0)) u_dut0 (
        .Clock_i (clk),
        .Reset_i (rst),
        .bus     (bus0.slave)
    );

    regfile_pc #(.BYPASS(1)) u_dut1 (
        .Clock_i (clk),
        .Reset_i (rst),
        .bus     (bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic we, input logic [2:0] wa, input word_t wd,
                          input logic [2:0] ra, input logic [2:0] rb, input logic inc);
        bus0.WrEn = we; bus0.WrAddr = wa; bus0.WrData = wd;
        bus0.RdAddrA = ra; bus0.RdAddrB = rb; bus0.IncrPC = inc;
        bus1.WrEn = we; bus1.WrAddr = wa; bus1.WrData = wd;
        bus1.RdAddrA = ra; bus1.RdAddrB = rb; bus1.IncrPC = inc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input word_t exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input word_t obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        set_in(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0);
        #1;
        push("pc_powerup", 16'h0002); check(bus0.PC);

        // Reset then idle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int idx = 0; idx < 7; idx++) begin
            set_in(1'b0, 3'd0, 16'h0000, 3'(idx), 3'(idx), 1'b0);
            #1;
            push($sformatf("rst_rdA_%0d", idx), 16'h0000); check(bus0.RdDataA);
        end
        push("rst_pc", 16'h0002);   check(bus0.PC);
        push("rst_wrap", 16'h0000); check(16'(bus0.PCWrap));

        // Write/read with and without bypass
        set_in(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 1'b0);
        #1;
        push("nobyp_rdA_same", 16'h0000); check(bus0.RdDataA);
        push("byp_rdA_same", 16'hBEEF);   check(bus1.RdDataA);
        push("byp_rdB_same", 16'hBEEF);   check(bus1.RdDataB);
        tick();
        set_in(1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b0);
        #1;
        push("nobyp_rdA_next", 16'hBEEF); check(bus0.RdDataA);
        push("nobyp_rdB_next", 16'hBEEF); check(bus0.RdDataB);
        push("byp_rdA_next", 16'hBEEF);   check(bus1.RdDataA);

        // Bypass suppressed under reset
        rst = 1'b1;
        set_in(1'b1, 3'd4, 16'h1234, 3'd4, 3'd4, 1'b0);
        #1;
        push("byp_rst_rdA", 16'h0000); check(bus1.RdDataA);
        tick();
        rst = 1'b0;
        set_in(1'b0, 3'd0, 16'h0000, 3'd4, 3'd3, 1'b0);
        #1;
        push("byp_rst_reg4", 16'h0000); check(bus1.RdDataA);
        push("rst_clr_reg3", 16'h0000); check(bus1.RdDataB);
        push("rst2_pc", 16'h0002);      check(bus0.PC);

        // Increment and wrap
        set_in(1'b1, 3'd7, 16'hFFFE, 3'd0, 3'd0, 1'b0);
        tick();
        set_in(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b1);
        #1;
        push("inc_pc0", 16'hFFFE);  check(bus0.PC);
        tick();
        push("inc_pc1", 16'hFFFF);  check(bus0.PC);
        push("inc_wrap1", 16'h0000); check(16'(bus0.PCWrap));
        tick();
        push("inc_pc2", 16'h0000);  check(bus0.PC);
        push("inc_wrap2", 16'h0001); check(16'(bus0.PCWrap));
        tick();
        push("inc_pc3", 16'h0001);  check(bus0.PC);
        push("inc_wrap3", 16'h0000); check(16'(bus0.PCWrap));

        // Collision: write to PC beats increment, even at all-ones
        set_in(1'b1, 3'd7, 16'hFFFF, 3'd0, 3'd0, 1'b0);
        tick();
        set_in(1'b1, 3'd7, 16'h0040, 3'd0, 3'd0, 1'b1);
        #1;
        push("pc_no_bypass", 16'hFFFF); check(bus1.PC);
        tick();
        set_in(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0);
        #1;
        push("coll_pc", 16'h0040);   check(bus0.PC);
        push("coll_wrap", 16'h0000); check(16'(bus0.PCWrap));

        // Write elsewhere plus increment: both apply
        set_in(1'b1, 3'd2, 16'h0040, 3'd2, 3'd2, 1'b1);
        tick();
        set_in(1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 1'b0);
        #1;
        push("both_reg2", 16'h0040); check(bus0.RdDataA);
        push("both_pc", 16'h0041);   check(bus0.PC);

        // Reset mid-increment
        set_in(1'b1, 3'd7, 16'h0010, 3'd0, 3'd0, 1'b0);
        tick();
        set_in(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b1);
        tick();
        push("rmi_pc1", 16'h0011); check(bus0.PC);
        rst = 1'b1;
        tick();
        push("rmi_pc2", 16'h0002);   check(bus0.PC);
        push("rmi_wrap", 16'h0000);  check(16'(bus0.PCWrap));
        rst = 1'b0;
        tick();
        push("rmi_pc3", 16'h0003); check(bus0.PC);
        set_in(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_pc.md
Name: regfile_pc

Overview:
- Parametrised register bank replacing the discrete per-register instances in the datapath: NUM_REGS general registers of DATA_W bits.
- Two asynchronous read ports and one synchronous write port.
- The register at PC_INDEX doubles as the program counter, with a dedicated increment mode.
- Sits between the control FSM and the bus mux. The instruction register stays a separate block.

Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 8, number of registers (power of two, >=2)
- ADDR_W, $clog2(NUM_REGS), register index width
- PC_INDEX, NUM_REGS-1, index of the register acting as program counter
- PC_RESET, 16'h0002, reset/initial value of the PC register; all other registers reset to 0
- BYPASS, 0, 1 = read ports forward same-cycle write data (write-through)

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous reset, active-high
- WrEn  in  1  write enable for write port
- WrAddr  in  ADDR_W  write index
- WrData  in  DATA_W  write data
- RdAddrA  in  ADDR_W  read index, port A
- RdDataA  out  DATA_W  read data, port A
- RdAddrB  in  ADDR_W  read index, port B
- RdDataB  out  DATA_W  read data, port B
- IncrPC  in  1  increment PC register by 1 at next edge
- PC  out  DATA_W  current PC register value, always driven
- PCWrap  out  1  registered flag: set for one cycle after PC incremented from all-ones to 0

Behaviour:
- Reset (sampled at posedge Clock while Reset=1):
  - All registers go to 0, except PC_INDEX, which goes to PC_RESET.
  - PCWrap goes to 0.
  - Reset overrides WrEn and IncrPC in the same cycle.
- The same values apply as simulation initial values, before the first reset.
- Write: at posedge, if WrEn=1 and Reset=0, reg[WrAddr] <= WrData. Latency 1 cycle. Other registers hold.
- Increment: at posedge, if IncrPC=1 and Reset=0, reg[PC_INDEX] <= reg[PC_INDEX]+1, modulo 2^DATA_W.
  - Wrap from all-ones to 0 is silent except for PCWrap.
- Simultaneous WrEn=1 with WrAddr=PC_INDEX and IncrPC=1: the write wins, the increment is dropped, and PCWrap=0.
- WrEn to any other index together with IncrPC: both take effect.
- Reads: RdDataA = reg[RdAddrA] and RdDataB = reg[RdAddrB], combinational. Both ports may address the same register.
- BYPASS=1: if WrEn=1 and RdAddrX==WrAddr, RdDataX = WrData in the same cycle. Bypass is suppressed while Reset=1.
  - No bypass of the increment result.
- BYPASS=0: reads return the pre-edge value; new data is visible the cycle after the write.
- PC output = reg[PC_INDEX], no bypass.
- PCWrap <= IncrPC & ~Reset & ~(WrEn & WrAddr==PC_INDEX) & (reg[PC_INDEX] == all-ones). It clears the following cycle unless re-asserted.
- Out-of-range indices (NUM_REGS not a power of two is illegal): no behaviour defined. The bench must not drive them.
- Reset asserted mid-sequence (e.g. during consecutive IncrPC): the register takes PC_RESET at that edge. Increment resumes from PC_RESET on the first cycle with Reset=0.

Decomposition:
- Shared package regfile_pkg:
  - default DATA_W/NUM_REGS constants
  - typedef reg_idx_t (ADDR_W bits)
  - typedef word_t (DATA_W bits)
  - PC_RESET default constant
- Sub-module reg_cell: one enabled register with parameter RESET_VAL, ports Clock, Reset, En, D, Q. Instantiated NUM_REGS times by generate.
- The PC increment/priority mux lives in the top, feeding the PC cell's D/En.

Test Plan:
- Reset then idle: assert Reset 1 cycle -> all RdData reads 0 for idx 0..6, PC=0x0002, PCWrap=0.
- Write/read, BYPASS=0: WrEn=1, WrAddr=3, WrData=0xBEEF, RdAddrA=3 -> RdDataA shows old value (0) that cycle and 0xBEEF the next; RdAddrB=3 also 0xBEEF.
- Bypass, BYPASS=1: same stimulus -> RdDataA=0xBEEF in the write cycle. With Reset=1 in that cycle -> RdDataA=0 and reg stays 0.
- Increment and wrap: write PC=0xFFFE, then IncrPC 3 cycles -> PC 0xFFFF, 0x0000, 0x0001. PCWrap=1 only in the cycle after the 0xFFFF->0x0000 edge.
- Collision: IncrPC=1, WrEn=1, WrAddr=7, WrData=0x0040 -> PC=0x0040, PCWrap=0. Repeat with WrAddr=2 -> reg2=0x0040 and PC incremented.
- Reset mid-increment: PC=0x0010, IncrPC held high, Reset pulsed 1 cycle -> PC sequence 0x0011, 0x0002 (reset edge), 0x0003.
